// File: rtl/vga_scan_reader.sv
// 640x480@60 VGA scan-out of a 160x120 framebuffer, each stored pixel shown as a 4x4 block.
// Optional colour-bar test pattern enabled with VGA_SCAN_TESTPATTERN_EN (adds port test_mode).
module vga_scan_reader #(
    parameter int BITS_PER_COLOUR_CHANNEL = 1,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic                                 clock,
    input  logic                                 resetn,
`ifdef VGA_SCAN_TESTPATTERN_EN
    input  logic                                 test_mode,
`endif
    output logic [14:0]                          rd_addr,
    input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0] rd_data,
    output logic                                 frame_start,
    output logic [9:0]                           VGA_R,
    output logic [9:0]                           VGA_G,
    output logic [9:0]                           VGA_B,
    output logic                                 VGA_HS,
    output logic                                 VGA_VS,
    output logic                                 VGA_BLANK,
    output logic                                 VGA_SYNC,
    output logic                                 VGA_CLK
);
    localparam int BPC = BITS_PER_COLOUR_CHANNEL;
    localparam int CW  = 3 * BPC;
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic          pix_en;
    logic [9:0]    hcount, vcount;
    logic          vis0, hs0, vs0;
    logic [7:0]    x0;
    logic [6:0]    y0;
    logic [14:0]   addr0;
    logic          vis1, hs1, vs1;
    logic          vis2, hs2, vs2;
    logic [CW-1:0] col2, col_next;
`ifdef VGA_SCAN_TESTPATTERN_EN
    logic [2:0]    bar1;
`endif

    function automatic logic [9:0] expand(input logic [BPC-1:0] c);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < 10; i++)
            r[9-i] = c[BPC-1-(i%BPC)];
        return r;
    endfunction

    always_comb begin
        vis0  = (hcount < H_VIS) && (vcount < V_VIS);
        hs0   = !((hcount >= H_SS) && (hcount < H_SE));
        vs0   = !((vcount >= V_SS) && (vcount < V_SE));
        x0    = hcount[9:2];
        y0    = vcount[8:2];
        addr0 = ({8'd0, y0} << 7) + ({8'd0, y0} << 5) + {7'd0, x0};
    end

    always_comb begin
        col_next = rd_data;
`ifdef VGA_SCAN_TESTPATTERN_EN
        if (test_mode)
            col_next = {{BPC{bar1[2]}}, {BPC{bar1[1]}}, {BPC{bar1[0]}}};
`endif
    end

    assign VGA_SYNC = 1'b0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pix_en      <= 1'b0;
            VGA_CLK     <= 1'b0;
            frame_start <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            rd_addr     <= '0;
            vis1        <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            vis2        <= 1'b0;
            hs2         <= 1'b1;
            vs2         <= 1'b1;
            col2        <= '0;
`ifdef VGA_SCAN_TESTPATTERN_EN
            bar1        <= '0;
`endif
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK   <= 1'b0;
        end else begin
            pix_en      <= !pix_en;
            VGA_CLK     <= pix_en;
            frame_start <= pix_en && (hcount == '0) && (vcount == '0);
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
                // Hold the last visible address during blanking so it never leaves the buffer.
                if (vis0)
                    rd_addr <= addr0;
                vis1 <= vis0;
                hs1  <= hs0;
                vs1  <= vs0;
`ifdef VGA_SCAN_TESTPATTERN_EN
                bar1 <= x0[7:5];
`endif
                vis2 <= vis1;
                hs2  <= hs1;
                vs2  <= vs1;
                col2 <= col_next;
                VGA_R     <= vis2 ? expand(col2[CW-1 -: BPC]) : '0;
                VGA_G     <= vis2 ? expand(col2[2*BPC-1 -: BPC]) : '0;
                VGA_B     <= vis2 ? expand(col2[BPC-1:0]) : '0;
                VGA_HS    <= hs2;
                VGA_VS    <= vs2;
                VGA_BLANK <= vis2;
            end
        end
    end
endmodule

// File: tb/tb_vga_scan_reader.sv
// Directed bench for vga_scan_reader: full-size timing instance plus a short-frame
// instance (8 lines) used to observe vertical sync and frame wrap quickly.
module tb_vga_scan_reader;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #10 clock = ~clock;

`ifdef VGA_SCAN_TESTPATTERN_EN
    logic test_mode = 1'b0;
`endif

    logic [14:0] rd_addr, rd_addr2;
    logic [2:0]  rd_data;
    logic [2:0]  rd_data2 = 3'b000;
    logic        frame_start, frame_start2;
    logic [9:0]  VGA_R, VGA_G, VGA_B, r2, g2, b2;
    logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;
    logic        hs2, vs2, blank2, sync2, clk2;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    vga_scan_reader dut (
        .clock(clock), .resetn(resetn),
`ifdef VGA_SCAN_TESTPATTERN_EN
        .test_mode(test_mode),
`endif
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
        .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK)
    );

    vga_scan_reader #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut2 (
        .clock(clock), .resetn(resetn),
`ifdef VGA_SCAN_TESTPATTERN_EN
        .test_mode(test_mode),
`endif
        .rd_addr(rd_addr2), .rd_data(rd_data2), .frame_start(frame_start2),
        .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
        .VGA_HS(hs2), .VGA_VS(vs2), .VGA_BLANK(blank2),
        .VGA_SYNC(sync2), .VGA_CLK(clk2)
    );

    // Registered RAM model: 3'b101 at address 0, 3'b010 elsewhere.
    always @(posedge clock)
        rd_data <= (rd_addr == 15'd0) ? 3'b101 : 3'b010;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    task automatic goto(input int n);
        while (edge_n < n) tick();
    endtask

    int hs_low, blank_hi;
    logic [14:0] max_addr;

    initial begin
        repeat (5) @(posedge clock);
        #1;
        chk("rst_hs", VGA_HS, 1);
        chk("rst_vs", VGA_VS, 1);
        chk("rst_blank", VGA_BLANK, 0);
        chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("rst_clk", VGA_CLK, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_fs", frame_start, 0);
        chk("sync_tied", VGA_SYNC, 0);
        resetn = 1'b1;
        edge_n = 0;

        goto(1);  chk("clk_e1", VGA_CLK, 0);
        goto(2);  chk("clk_rise_e2", VGA_CLK, 1);
        chk("fs_e2", frame_start, 1);
        chk("addr_p0", rd_addr, 0);
        goto(3);  chk("fs_e3", frame_start, 0);
        goto(5);  chk("blank_before_lat", VGA_BLANK, 0);
        goto(6);  chk("blank_first", VGA_BLANK, 1);
        chk("rgb_first", {VGA_R, VGA_G, VGA_B}, {10'h3FF, 10'h000, 10'h3FF});
        chk("hs_first", VGA_HS, 1);
        goto(8);  chk("addr_p3", rd_addr, 0);
        goto(10); chk("addr_p4", rd_addr, 1);
        goto(14); chk("rgb_p4", {VGA_R, VGA_G, VGA_B}, {10'h000, 10'h3FF, 10'h000});
        goto(1284); chk("blank_p639", VGA_BLANK, 1);
        goto(1286); chk("blank_p640", VGA_BLANK, 0);
        chk("rgb_blank", {VGA_R, VGA_G, VGA_B}, 0);
        goto(1316); chk("hs_p655", VGA_HS, 1);
        goto(1318); chk("hs_p656", VGA_HS, 0);
        goto(1508); chk("hs_p751", VGA_HS, 0);
        goto(1510); chk("hs_p752", VGA_HS, 1);
        goto(1602); chk("addr_line1", rd_addr, 0);

        hs_low = 0;
        blank_hi = 0;
        max_addr = '0;
        for (int p = 800; p < 1600; p++) begin
            goto(2 * p + 6);
            if (!VGA_HS) hs_low++;
            if (VGA_BLANK) blank_hi++;
            if (rd_addr > max_addr) max_addr = rd_addr;
        end
        chk("hs_width_line1", hs_low, 96);
        chk("blank_width_line1", blank_hi, 640);
        chk("addr_max_line1", max_addr, 159);

        goto(6402); chk("addr_line4", rd_addr, 160);
        goto(6406); chk("short_blank_line4", blank2, 0);
        chk("vs_line4", VGA_VS, 1);
        goto(8004); chk("short_vs_before", vs2, 1);
        goto(8006); chk("short_vs_start", vs2, 0);
        goto(11204); chk("short_vs_end", vs2, 0);
        goto(11206); chk("short_vs_after", vs2, 1);
        goto(12801); chk("short_fs_pre", frame_start2, 0);
        goto(12802); chk("short_fs_wrap", frame_start2, 1);
        chk("main_fs_none", frame_start, 0);
        goto(12803); chk("short_fs_post", frame_start2, 0);

        goto(12901);
        chk("mid_blank_pre", VGA_BLANK, 1);
        #3;
        resetn = 1'b0;
        #1;
        chk("mid_clk", VGA_CLK, 0);
        chk("mid_blank", VGA_BLANK, 0);
        chk("mid_hs", VGA_HS, 1);
        chk("mid_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("mid_addr", rd_addr, 0);
        repeat (2) @(posedge clock);
        #1;
`ifdef VGA_SCAN_TESTPATTERN_EN
        test_mode = 1'b1;
`endif
        resetn = 1'b1;
        edge_n = 0;
        goto(2);
        chk("mid_fs", frame_start, 1);
        chk("mid_addr_restart", rd_addr, 0);
        goto(262);
`ifdef VGA_SCAN_TESTPATTERN_EN
        chk("bar_x32", {VGA_R, VGA_G, VGA_B}, {10'h000, 10'h000, 10'h3FF});
`else
        chk("ram_x32", {VGA_R, VGA_G, VGA_B}, {10'h000, 10'h3FF, 10'h000});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
